// File: rtl/rv32_types.sv
// rtl/rv32_types.sv - shared RV32 pipeline types, buffers and memory-stage states
package rv32_types;

  typedef logic [31:0] rv32_word;

  localparam rv32_word RV_NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic    reg_write;
    logic [4:0] rd;
    mem_op_t mem_op;
  } decoded_instr_t;

  typedef struct packed {
    rv32_word       instr;
    rv32_word       pc;
    decoded_instr_t decoded_instr;
    rv32_word       mem_addr;
    rv32_word       wb_result;
  } exec_mem_buffer_t;

  typedef struct packed {
    rv32_word       instr;
    rv32_word       pc;
    decoded_instr_t decoded_instr;
    rv32_word       wb_result;
  } mem_wb_buffer_t;

  typedef logic [1:0] mem_state_t;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MEM_HOLD = 2'd2;

  function automatic decoded_instr_t create_nop_ctrl();
    decoded_instr_t c;
    c.reg_write = 1'b0;
    c.rd        = 5'd0;
    c.mem_op    = MEM_NONE;
    return c;
  endfunction

endpackage

// File: rtl/rv32_mem_stage_if.sv
// rtl/rv32_mem_stage_if.sv - data-memory request/response port of the memory stage
interface rv32_mem_stage_if;
  import rv32_types::*;

  logic     dmem_req_valid;
  logic     dmem_req_ready;
  rv32_word dmem_addr;
  logic     dmem_we;
  logic [3:0] dmem_be;
  rv32_word dmem_wdata;
  logic     dmem_rsp_valid;
  rv32_word dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

endinterface

// File: rtl/rv32_load_store_align.sv
// rtl/rv32_load_store_align.sv - byte-lane steering for stores, extraction/extension for loads
module rv32_load_store_align
  import rv32_types::*;
(
  input  mem_op_t    mem_op,
  input  logic [1:0] off,
  input  rv32_word   rs2,
  input  rv32_word   rdata,
  output logic [3:0] be,
  output rv32_word   wdata,
  output rv32_word   load_data,
  output logic       misaligned
);

  rv32_word   shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Shift the addressed lane down to bit 0 so byte/half extraction is offset-free.
  assign shifted = rdata >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = shifted[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata      = rs2;
    load_data  = rdata;
    misaligned = 1'b0;
    case (mem_op)
      MEM_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      MEM_LBU: load_data = {24'd0, byte_v};
      MEM_LH: begin
        load_data  = {{16{half_v[15]}}, half_v};
        misaligned = off[0];
      end
      MEM_LHU: begin
        load_data  = {16'd0, half_v};
        misaligned = off[0];
      end
      MEM_LW:  misaligned = |off;
      MEM_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{rs2[7:0]}};
      end
      MEM_SH: begin
        be         = 4'b0011 << off;
        wdata      = {2{rs2[15:0]}};
        misaligned = off[0];
      end
      MEM_SW:  misaligned = |off;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_mem_stage.sv
// rtl/rv32_mem_stage.sv - RV32 memory stage: exec->mem buffer in, mem->wb buffer out
module rv32_mem_stage
  import rv32_types::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  exec_mem_buffer_t exec_mem_buff,
  output mem_wb_buffer_t   mem_wb_buff,
  input  logic             stop,
  output logic             mem_stall,
  output rv32_word         wb_bypass,
  output logic             misaligned,
  rv32_mem_stage_if.master dmem
);

  localparam mem_wb_buffer_t MEM_WB_RESET = '{
    instr: RV_NOP, pc: 32'd0, decoded_instr: create_nop_ctrl(), wb_result: 32'd0
  };

  mem_state_t     state_q, state_d;
  mem_wb_buffer_t mem_wb_q, mem_wb_d;
  mem_wb_buffer_t hold_q, hold_d;
  logic           misaligned_q, misaligned_d;

  mem_op_t    op;
  logic       is_mem, is_store, align_err;
  logic [3:0] lane_be;
  rv32_word   lane_wdata, load_data;
  mem_wb_buffer_t pass_res, access_res, nop_res;

  assign op       = exec_mem_buff.decoded_instr.mem_op;
  assign is_mem   = (op != MEM_NONE);
  assign is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);

  rv32_load_store_align u_align (
    .mem_op     (op),
    .off        (exec_mem_buff.mem_addr[1:0]),
    .rs2        (exec_mem_buff.wb_result),
    .rdata      (dmem.dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data),
    .misaligned (align_err)
  );

  always_comb begin
    pass_res.instr         = exec_mem_buff.instr;
    pass_res.pc            = exec_mem_buff.pc;
    pass_res.decoded_instr = exec_mem_buff.decoded_instr;
    pass_res.wb_result     = exec_mem_buff.wb_result;

    access_res           = pass_res;
    access_res.wb_result = is_store ? exec_mem_buff.wb_result : load_data;

    nop_res.instr         = RV_NOP;
    nop_res.pc            = exec_mem_buff.pc;
    nop_res.decoded_instr = create_nop_ctrl();
    nop_res.wb_result     = 32'd0;
  end

  // Request fields come straight from the held exec buffer, so they stay stable until accepted.
  assign dmem.dmem_addr  = {exec_mem_buff.mem_addr[31:2], 2'b00};
  assign dmem.dmem_we    = is_store;
  assign dmem.dmem_be    = lane_be;
  assign dmem.dmem_wdata = lane_wdata;

  always_comb begin
    state_d             = state_q;
    mem_wb_d            = mem_wb_q;
    hold_d              = hold_q;
    misaligned_d        = 1'b0;
    dmem.dmem_req_valid = 1'b0;
    mem_stall           = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (!is_mem) begin
          if (!stop) mem_wb_d = pass_res;
        end else if (align_err) begin
          if (!stop) begin
            mem_wb_d     = nop_res;
            misaligned_d = 1'b1;
          end
        end else begin
          dmem.dmem_req_valid = 1'b1;
          mem_stall           = 1'b1;
          if (dmem.dmem_req_ready) state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        mem_stall = !dmem.dmem_rsp_valid;
        if (dmem.dmem_rsp_valid) begin
          if (!stop) begin
            mem_wb_d = access_res;
            state_d  = MEM_IDLE;
          end else begin
            hold_d  = access_res;
            state_d = MEM_HOLD;
          end
        end
      end
      MEM_HOLD: begin
        if (!stop) begin
          mem_wb_d = hold_q;
          state_d  = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= MEM_IDLE;
      mem_wb_q     <= MEM_WB_RESET;
      hold_q       <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_wb_q     <= mem_wb_d;
      hold_q       <= hold_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign mem_wb_buff = mem_wb_q;
  assign wb_bypass   = mem_wb_q.wb_result;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_rv32_mem_stage.sv
// tb/tb_rv32_mem_stage.sv - directed self-checking bench for rv32_mem_stage
module tb_rv32_mem_stage;
  import rv32_types::*;

  logic             clk = 1'b0;
  logic             resetn;
  exec_mem_buffer_t exec_mem_buff;
  mem_wb_buffer_t   mem_wb_buff;
  logic             stop;
  logic             mem_stall;
  rv32_word         wb_bypass;
  logic             misaligned;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  rv32_mem_stage_if dmem ();

  rv32_mem_stage dut (
    .clk           (clk),
    .resetn        (resetn),
    .exec_mem_buff (exec_mem_buff),
    .mem_wb_buff   (mem_wb_buff),
    .stop          (stop),
    .mem_stall     (mem_stall),
    .wb_bypass     (wb_bypass),
    .misaligned    (misaligned),
    .dmem          (dmem.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input mem_op_t op, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] addr, input logic [31:0] wbr);
    exec_mem_buff.instr                   = instr;
    exec_mem_buff.pc                      = pc;
    exec_mem_buff.decoded_instr.reg_write = 1'b1;
    exec_mem_buff.decoded_instr.rd        = 5'd3;
    exec_mem_buff.decoded_instr.mem_op    = op;
    exec_mem_buff.mem_addr                = addr;
    exec_mem_buff.wb_result               = wbr;
  endtask

  task automatic set_nop();
    exec_mem_buff.instr         = RV_NOP;
    exec_mem_buff.pc            = 32'd0;
    exec_mem_buff.decoded_instr = create_nop_ctrl();
    exec_mem_buff.mem_addr      = 32'd0;
    exec_mem_buff.wb_result     = 32'd0;
  endtask

  // Best-case access: accepted in the request cycle, response on the next cycle.
  task automatic do_access(input mem_op_t op, input logic [31:0] addr, input logic [31:0] rdata);
    set_op(op, 32'h0000_2083, 32'h200, addr, 32'd0);
    dmem.dmem_req_ready = 1'b1;
    #1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata     = rdata;
    #1;
    chk("best_case_stall_rsp_cycle", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    set_nop();
  endtask

  initial begin
    resetn              = 1'b0;
    stop                = 1'b0;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rdata     = 32'd0;
    set_nop();
    tick();
    tick();
    chk("reset_instr", mem_wb_buff.instr, RV_NOP);
    chk("reset_pc", mem_wb_buff.pc, 32'd0);
    chk("reset_wb", mem_wb_buff.wb_result, 32'd0);
    chk("reset_stall", {31'd0, mem_stall}, 32'd0);
    chk("reset_req_valid", {31'd0, dmem.dmem_req_valid}, 32'd0);
    chk("reset_misaligned", {31'd0, misaligned}, 32'd0);
    resetn = 1'b1;
    tick();

    // ADD passes through in one cycle
    set_op(MEM_NONE, 32'h0020_81B3, 32'h100, 32'd0, 32'h15);
    #1;
    chk("add_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("add_wb", mem_wb_buff.wb_result, 32'h15);
    chk("add_bypass", wb_bypass, 32'h15);
    chk("add_pc", mem_wb_buff.pc, 32'h100);

    // SH lane check only (request withdrawn before any edge with ready)
    set_op(MEM_SH, 32'h0020_9123, 32'h104, 32'h1002, 32'h1234_ABCD);
    #1;
    chk("sh_be", {28'd0, dmem.dmem_be}, 32'hC);
    chk("sh_wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
    set_nop();
    tick();

    // SB with ack after three waiting cycles
    set_op(MEM_SB, 32'h0020_8123, 32'h108, 32'h1002, 32'hAABB_CCDD);
    dmem.dmem_req_ready = 1'b1;
    #1;
    chk("sb_addr", dmem.dmem_addr, 32'h1000);
    chk("sb_be", {28'd0, dmem.dmem_be}, 32'h4);
    chk("sb_wdata", dmem.dmem_wdata, 32'hDDDD_DDDD);
    chk("sb_we", {31'd0, dmem.dmem_we}, 32'd1);
    chk("sb_req_valid", {31'd0, dmem.dmem_req_valid}, 32'd1);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) dmem.dmem_rsp_valid = 1'b1;
      #1;
      if (mem_stall) cnt++;
      if (c == 1) chk("sb_wait_req_valid", {31'd0, dmem.dmem_req_valid}, 32'd0);
      tick();
      dmem.dmem_req_ready = 1'b0;
    end
    dmem.dmem_rsp_valid = 1'b0;
    set_nop();
    chk("sb_stall_cycles", cnt, 32'd4);
    chk("sb_wb_instr", mem_wb_buff.instr, 32'h0020_8123);
    chk("sb_wb_result", mem_wb_buff.wb_result, 32'hAABB_CCDD);

    // Loads with sign/zero extension
    do_access(MEM_LB, 32'h2001, 32'h0000_8000);
    chk("lb_wb", mem_wb_buff.wb_result, 32'hFFFF_FF80);
    do_access(MEM_LBU, 32'h2001, 32'h0000_8000);
    chk("lbu_wb", mem_wb_buff.wb_result, 32'h0000_0080);
    do_access(MEM_LH, 32'h2002, 32'h8001_0000);
    chk("lh_wb", mem_wb_buff.wb_result, 32'hFFFF_8001);

    // LW with ready low for two cycles
    set_op(MEM_LW, 32'h0000_2283, 32'h300, 32'h3000, 32'd0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      dmem.dmem_req_ready = (c == 2);
      #1;
      if (dmem.dmem_req_valid) cnt++;
      if (c == 1) chk("lw_hold_addr", dmem.dmem_addr, 32'h3000);
      if (c == 1) chk("lw_hold_stall", {31'd0, mem_stall}, 32'd1);
      if (c == 3) dmem.dmem_rsp_valid = 1'b1;
      if (c == 3) dmem.dmem_rdata = 32'h1234_5678;
      tick();
    end
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_req_ready = 1'b0;
    set_nop();
    chk("lw_valid_cycles", cnt, 32'd3);
    chk("lw_wb", mem_wb_buff.wb_result, 32'h1234_5678);

    // Misaligned LW
    set_op(MEM_LW, 32'h0000_2283, 32'h304, 32'h3002, 32'h55);
    #1;
    chk("mis_req_valid", {31'd0, dmem.dmem_req_valid}, 32'd0);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    set_nop();
    chk("mis_pulse", {31'd0, misaligned}, 32'd1);
    chk("mis_instr", mem_wb_buff.instr, RV_NOP);
    chk("mis_wb", mem_wb_buff.wb_result, 32'd0);
    tick();
    chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);

    // Response under stop goes to HOLD
    set_op(MEM_NONE, 32'h0020_81B3, 32'h400, 32'd0, 32'h77);
    tick();
    set_op(MEM_LW, 32'h0000_2283, 32'h404, 32'h4000, 32'd0);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    stop                = 1'b1;
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata     = 32'hCAFE_F00D;
    #1;
    chk("stop_rsp_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    set_op(MEM_LW, 32'h0000_2283, 32'h408, 32'h5000, 32'd0);
    #1;
    chk("hold_no_req", {31'd0, dmem.dmem_req_valid}, 32'd0);
    chk("hold_wb_unchanged", mem_wb_buff.wb_result, 32'h77);
    tick();
    chk("hold_wb_still", mem_wb_buff.wb_result, 32'h77);
    stop = 1'b0;
    tick();
    set_nop();
    chk("hold_release_wb", mem_wb_buff.wb_result, 32'hCAFE_F00D);
    chk("hold_release_pc", mem_wb_buff.pc, 32'h404);
    tick();

    // Reset while an access is outstanding
    set_op(MEM_LW, 32'h0000_2283, 32'h500, 32'h6000, 32'd0);
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    set_nop();
    #1;
    chk("wait_stall", {31'd0, mem_stall}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_wait_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wait_instr", mem_wb_buff.instr, RV_NOP);
    chk("rst_wait_bypass", wb_bypass, 32'd0);
    tick();
    resetn = 1'b1;
    set_op(MEM_NONE, 32'h0020_81B3, 32'h504, 32'd0, 32'h99);
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata     = 32'hDEAD_0000;
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    set_nop();
    chk("late_rsp_ignored", mem_wb_buff.wb_result, 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
